// File: rtl/dca_matrix_mreg2store_flex_pkg.sv
// Shared definitions for the mreg-to-store row drainer: FSM encoding
// and width derivations for the matrix/tensor row datapath.
package dca_matrix_mreg2store_flex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } m2s_state_e;

    // Row counter must hold 0..num_rows inclusive.
    function automatic int bw_row_cnt(input int num_rows);
        return $clog2(num_rows + 1);
    endfunction

    function automatic int bw_tensor_row(input int size, input int bw_scalar);
        return size * bw_scalar;
    endfunction

endpackage

// File: rtl/dca_matrix_mreg2store_flex_prefetch.sv
// dca_row_prefetch_buffer: one-row holding register with valid bit.
// Ports: load/load_data fill it, consume empties it, flush discards it.
module dca_row_prefetch_buffer #(
    parameter int BW_DATA = 128
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               load,
    input  logic               consume,
    input  logic               flush,
    input  logic [BW_DATA-1:0] load_data,
    output logic               valid,
    output logic [BW_DATA-1:0] data
);

    logic               valid_q, valid_d;
    logic [BW_DATA-1:0] data_q, data_d;

    // Load wins over consume so a transfer and refill in one cycle
    // keep the buffer full (one row per cycle).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/dca_matrix_mreg2store_flex.sv
// Drains num_row rows from the mreg FIFO head to a store consumer,
// popping exactly num_row rows per job whatever the consumer's rlast does.
// Ports: clk/rstnn/clear/enable control; storereg_w* job request;
// mreg_move_* mreg head/pop; store_tensor_row_* consumer handshake;
// busy/done/length_error status.
module dca_matrix_mreg2store_flex
    import dca_matrix_mreg2store_flex_pkg::*;
#(
    parameter int MATRIX_SIZE_PARA  = 4,
    parameter int BW_TENSOR_SCALAR  = 32,
    parameter int OUTPUT_REGISTERED = 0,
    localparam int MATRIX_NUM_ROW   = MATRIX_SIZE_PARA,
    localparam int BW_TENSOR_ROW    = bw_tensor_row(MATRIX_SIZE_PARA, BW_TENSOR_SCALAR),
    localparam int BW_ROW_CNT       = bw_row_cnt(MATRIX_NUM_ROW)
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     clear,
    input  logic                     enable,
    output logic                     busy,
    output logic                     storereg_wready,
    input  logic                     storereg_wrequest,
    input  logic [BW_ROW_CNT-1:0]    storereg_wnum_row,
    output logic                     mreg_move_renable,
    input  logic [BW_TENSOR_ROW-1:0] mreg_move_rdata_list1d,
    input  logic                     store_tensor_row_rvalid,
    input  logic                     store_tensor_row_rlast,
    output logic                     store_tensor_row_rready,
    output logic [BW_TENSOR_ROW-1:0] store_tensor_row_rdata,
    output logic                     done,
    output logic                     length_error
);

    localparam logic [BW_ROW_CNT-1:0] ROWS_MAX = BW_ROW_CNT'(MATRIX_NUM_ROW);

    m2s_state_e state_q, state_d;

    logic [BW_ROW_CNT-1:0] num_row_q, num_row_d;
    logic [BW_ROW_CNT-1:0] pop_cnt_q, pop_cnt_d;
    logic [BW_ROW_CNT-1:0] xfer_cnt_q, xfer_cnt_d;
    logic                  len_err_q, len_err_d;

    logic [BW_ROW_CNT-1:0] xfer_next;
    logic [BW_ROW_CNT-1:0] pop_next;
    logic                  en_ok;
    logic                  in_stream;
    logic                  in_drain;
    logic                  rows_left;
    logic                  rready;
    logic                  xfer;
    logic                  last_row;
    logic                  term;
    logic                  early;
    logic                  pbuf_load;
    logic                  pbuf_valid;
    logic                  renable;
    logic                  drain_end;

    always_comb begin
        en_ok     = enable & ~clear;
        in_stream = (state_q == ST_STREAM);
        in_drain  = (state_q == ST_DRAIN);
        rows_left = (pop_cnt_q < num_row_q);

        if (OUTPUT_REGISTERED != 0) begin
            rready = in_stream & pbuf_valid & en_ok;
        end else begin
            rready = in_stream & en_ok;
        end

        xfer      = store_tensor_row_rvalid & rready;
        xfer_next = xfer_cnt_q + BW_ROW_CNT'(1);
        last_row  = (xfer_next == num_row_q);
        term      = xfer & (store_tensor_row_rlast | last_row);
        early     = xfer & store_tensor_row_rlast & ~last_row;

        // No refill on the job's final transfer: the row would be
        // discarded and throw off the pop count.
        if (OUTPUT_REGISTERED != 0) begin
            pbuf_load = in_stream & en_ok & rows_left
                      & (~pbuf_valid | xfer) & ~term;
            renable   = pbuf_load;
        end else begin
            pbuf_load = 1'b0;
            renable   = xfer;
        end
        renable   = renable | (in_drain & en_ok & rows_left);

        pop_next  = pop_cnt_q + BW_ROW_CNT'(renable);
        drain_end = in_drain & en_ok & (pop_next == num_row_q);
    end

    always_comb begin
        state_d    = state_q;
        num_row_d  = num_row_q;
        pop_cnt_d  = pop_cnt_q;
        xfer_cnt_d = xfer_cnt_q;
        len_err_d  = len_err_q;
        if (clear) begin
            state_d    = ST_IDLE;
            num_row_d  = '0;
            pop_cnt_d  = '0;
            xfer_cnt_d = '0;
            len_err_d  = 1'b0;
        end else if (enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (storereg_wrequest) begin
                        num_row_d  = (storereg_wnum_row == '0) ?
                                     ROWS_MAX : storereg_wnum_row;
                        pop_cnt_d  = '0;
                        xfer_cnt_d = '0;
                        len_err_d  = 1'b0;
                        state_d    = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    pop_cnt_d = pop_next;
                    if (xfer) begin
                        xfer_cnt_d = xfer_next;
                    end
                    if (early) begin
                        len_err_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end else if (term) begin
                        if (!store_tensor_row_rlast) begin
                            len_err_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    pop_cnt_d = pop_next;
                    if (drain_end) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q    <= ST_IDLE;
            num_row_q  <= '0;
            pop_cnt_q  <= '0;
            xfer_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_row_q  <= num_row_d;
            pop_cnt_q  <= pop_cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    generate
        if (OUTPUT_REGISTERED != 0) begin : g_pbuf
            logic pbuf_flush;

            assign pbuf_flush = clear | (in_stream & en_ok & early);

            dca_row_prefetch_buffer #(
                .BW_DATA (BW_TENSOR_ROW)
            ) u_pbuf (
                .clk       (clk),
                .rstnn     (rstnn),
                .load      (pbuf_load),
                .consume   (xfer),
                .flush     (pbuf_flush),
                .load_data (mreg_move_rdata_list1d),
                .valid     (pbuf_valid),
                .data      (store_tensor_row_rdata)
            );
        end else begin : g_comb
            assign pbuf_valid             = 1'b0;
            assign store_tensor_row_rdata = mreg_move_rdata_list1d;
        end
    endgenerate

    assign busy                    = (state_q != ST_IDLE);
    assign storereg_wready         = (state_q == ST_IDLE);
    assign mreg_move_renable       = renable;
    assign store_tensor_row_rready = rready;
    assign done                    = (in_stream & term & ~early) | drain_end;
    assign length_error            = len_err_q;

endmodule

// File: tb/tb_dca_matrix_mreg2store_flex.sv
// Bench for dca_matrix_mreg2store_flex: one combinational-output and one
// registered-output instance driven with directed and random drain jobs.
module tb_dca_matrix_mreg2store_flex;

    localparam int N = 4;
    localparam int W = 128;
    localparam int C = 3;

    logic clk = 1'b0;
    logic rstnn = 1'b0;
    always #5 clk = ~clk;

    logic           clear_s [2];
    logic           enable_s[2];
    logic           wreq    [2];
    logic [C-1:0]   wnum    [2];
    logic           rvalid  [2];
    logic           rlast   [2];
    logic           busy    [2];
    logic           wready  [2];
    logic           renable [2];
    logic           rready  [2];
    logic           done_s  [2];
    logic           lerr    [2];
    logic [W-1:0]   rdata   [2];
    logic [W-1:0]   mrow    [2];

    // Model of mreg contents: a row array indexed by absolute pop count.
    logic [W-1:0]   rows [2][16];
    int             rp   [2] = '{0, 0};
    int             xtot [2] = '{0, 0};
    int             dtot [2] = '{0, 0};
    int             pbase[2];
    int             xbase[2];

    int errs   = 0;
    int checks = 0;

    assign mrow[0] = rows[0][rp[0] % 16];
    assign mrow[1] = rows[1][rp[1] % 16];

    dca_matrix_mreg2store_flex #(
        .MATRIX_SIZE_PARA  (N),
        .BW_TENSOR_SCALAR  (32),
        .OUTPUT_REGISTERED (0)
    ) u0 (
        .clk                     (clk),
        .rstnn                   (rstnn),
        .clear                   (clear_s[0]),
        .enable                  (enable_s[0]),
        .busy                    (busy[0]),
        .storereg_wready         (wready[0]),
        .storereg_wrequest       (wreq[0]),
        .storereg_wnum_row       (wnum[0]),
        .mreg_move_renable       (renable[0]),
        .mreg_move_rdata_list1d  (mrow[0]),
        .store_tensor_row_rvalid (rvalid[0]),
        .store_tensor_row_rlast  (rlast[0]),
        .store_tensor_row_rready (rready[0]),
        .store_tensor_row_rdata  (rdata[0]),
        .done                    (done_s[0]),
        .length_error            (lerr[0])
    );

    dca_matrix_mreg2store_flex #(
        .MATRIX_SIZE_PARA  (N),
        .BW_TENSOR_SCALAR  (32),
        .OUTPUT_REGISTERED (1)
    ) u1 (
        .clk                     (clk),
        .rstnn                   (rstnn),
        .clear                   (clear_s[1]),
        .enable                  (enable_s[1]),
        .busy                    (busy[1]),
        .storereg_wready         (wready[1]),
        .storereg_wrequest       (wreq[1]),
        .storereg_wnum_row       (wnum[1]),
        .mreg_move_renable       (renable[1]),
        .mreg_move_rdata_list1d  (mrow[1]),
        .store_tensor_row_rvalid (rvalid[1]),
        .store_tensor_row_rlast  (rlast[1]),
        .store_tensor_row_rready (rready[1]),
        .store_tensor_row_rdata  (rdata[1]),
        .done                    (done_s[1]),
        .length_error            (lerr[1])
    );

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mreg pops take effect at the clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (renable[i]) rp[i] <= rp[i] + 1;
        end
    end

    // Every accepted row must be the next mreg row of the current job.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rvalid[i] && rready[i]) begin
                chk($sformatf("rdata%0d_x%0d", i, xtot[i] - xbase[i]),
                    rdata[i], rows[i][(pbase[i] + xtot[i] - xbase[i]) % 16]);
                xtot[i] <= xtot[i] + 1;
            end
            if (done_s[i]) dtot[i] <= dtot[i] + 1;
        end
    end

    task automatic start_job(input int i, input int n);
        int nn;
        nn = (n == 0) ? N : n;
        for (int k = 0; k < nn; k++) begin
            rows[i][(rp[i] + k) % 16] = {$urandom, $urandom, $urandom, $urandom};
        end
        pbase[i] = rp[i];
        xbase[i] = xtot[i];
        wreq[i]  = 1'b1;
        wnum[i]  = C'(n);
        @(posedge clk);
        #1 wreq[i] = 1'b0;
    endtask

    // vmode: 0 rvalid always high, 1 toggling, 2 random.
    // last_at: transfer index carrying rlast (>= num rows means never).
    task automatic run_job(input int i, input int n, input int last_at,
                           input int vmode, input bit gap);
        int nn, xp, ep, cyc, t, p0, d0, hold;
        bit gapped;
        nn = (n == 0) ? N : n;
        xp = (last_at < nn) ? last_at + 1 : nn;
        ep = (last_at == nn - 1) ? 0 : 1;
        p0 = rp[i];
        d0 = dtot[i];
        start_job(i, n);
        cyc = 0;
        gapped = 1'b0;
        while (busy[i] && cyc < 60) begin
            t = xtot[i] - xbase[i];
            if (gap && !gapped && t == xp) begin
                gapped = 1'b1;
                enable_s[i] = 1'b0;
                rvalid[i] = 1'b0;
                rlast[i] = 1'b0;
                hold = rp[i];
                repeat (3) begin
                    @(negedge clk);
                    chk("gap_renable", renable[i], 0);
                    chk("gap_busy", busy[i], 1);
                    @(posedge clk);
                    #1;
                end
                chk("gap_pops", rp[i], hold);
                enable_s[i] = 1'b1;
            end
            case (vmode)
                0: rvalid[i] = 1'b1;
                1: rvalid[i] = (cyc % 2 == 0);
                default: rvalid[i] = 1'($urandom % 2);
            endcase
            rlast[i] = rvalid[i] && (t == last_at);
            @(posedge clk);
            #1;
            cyc++;
        end
        rvalid[i] = 1'b0;
        rlast[i]  = 1'b0;
        chk($sformatf("timeout%0d", i), busy[i], 0);
        chk($sformatf("xfers%0d", i), xtot[i] - xbase[i], xp);
        chk($sformatf("pops%0d", i), rp[i] - p0, nn);
        chk($sformatf("done%0d", i), dtot[i] - d0, 1);
        chk($sformatf("lerr%0d", i), lerr[i], ep);
        chk($sformatf("wready%0d", i), wready[i], 1);
        chk($sformatf("rready_after%0d", i), rready[i], 0);
        if (vmode == 0 && !gap) begin
            chk($sformatf("cycles%0d", i), cyc, nn + i);
        end
        if (busy[i]) begin
            clear_s[i] = 1'b1;
            @(posedge clk);
            #1 clear_s[i] = 1'b0;
        end
    endtask

    initial begin
        int d0, x0, p0;
        for (int i = 0; i < 2; i++) begin
            clear_s[i]  = 1'b0;
            enable_s[i] = 1'b1;
            wreq[i]     = 1'b0;
            wnum[i]     = '0;
            rvalid[i]   = 1'b0;
            rlast[i]    = 1'b0;
            pbase[i]    = 0;
            xbase[i]    = 0;
        end
        for (int k = 0; k < 16; k++) begin
            rows[0][k] = '0;
            rows[1][k] = '0;
        end

        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", busy[i], 0);
            chk("rst_wready", wready[i], 1);
            chk("rst_rready", rready[i], 0);
            chk("rst_renable", renable[i], 0);
            chk("rst_done", done_s[i], 0);
            chk("rst_lerr", lerr[i], 0);
        end
        chk("rst_rdata1", rdata[1], 0);
        @(posedge clk);
        #1 rstnn = 1'b1;
        @(posedge clk);
        #1;

        run_job(0, 4, 3, 0, 0);
        run_job(0, 3, 0, 0, 0);
        run_job(0, 2, 9, 0, 0);
        run_job(0, 3, 0, 0, 1);

        // Clear after one transfer: abort without done.
        d0 = dtot[0];
        x0 = xtot[0];
        start_job(0, 4);
        rvalid[0] = 1'b1;
        @(posedge clk);
        #1 rvalid[0] = 1'b0;
        clear_s[0] = 1'b1;
        @(negedge clk);
        chk("clr_done", done_s[0], 0);
        @(posedge clk);
        #1 clear_s[0] = 1'b0;
        chk("clr_busy", busy[0], 0);
        chk("clr_wready", wready[0], 1);
        chk("clr_lerr", lerr[0], 0);
        chk("clr_xfers", xtot[0] - x0, 1);
        chk("clr_ndone", dtot[0] - d0, 0);

        // Request coinciding with done is ignored.
        p0 = rp[0];
        start_job(0, 1);
        rvalid[0] = 1'b1;
        rlast[0]  = 1'b1;
        wreq[0]   = 1'b1;
        @(negedge clk);
        chk("rqd_done", done_s[0], 1);
        chk("rqd_wready", wready[0], 0);
        @(posedge clk);
        #1;
        wreq[0]   = 1'b0;
        rvalid[0] = 1'b0;
        rlast[0]  = 1'b0;
        chk("rqd_busy", busy[0], 0);
        chk("rqd_wready2", wready[0], 1);
        chk("rqd_pops", rp[0] - p0, 1);
        chk("rqd_lerr", lerr[0], 0);

        run_job(1, 4, 3, 1, 0);
        run_job(1, 4, 3, 0, 0);
        run_job(1, 3, 0, 0, 0);
        run_job(1, 2, 9, 0, 0);

        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 2; i++) begin
                run_job(i, $urandom_range(0, 4), $urandom_range(0, 4),
                        $urandom_range(0, 2), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
